ascon_block_packer: RTL and testbench
=====================================

// Module: ascon_block_packer
// PURPOSE
//  Upstream feeder of the rate-XOR stage: packs a byte stream (AD/plaintext/ciphertext)
//  into 128-bit rate blocks and applies ASCON-AEAD128 padding (0x01 then zeros).
//  Presents data_o/block_valid_o to the control FSM; the FSM pulses block_ready_i
//  in the cycle it drives enable_xb_i of the XOR stage with data_o.
// PARAMETERS
//  RATE_BYTES  16     bytes per block; only 16 supported (ASCON-AEAD128 rate)
//  PAD_BYTE    8'h01  byte written immediately after the last data byte
// PORTS
//  clock_i        in   1    single clock, rising edge
//  reset_i        in   1    asynchronous, active-high reset
//  byte_i         in   8    input data byte
//  byte_valid_i   in   1    byte_i valid
//  byte_last_i    in   1    qualifies byte_i as last byte of message
//  byte_ready_o   out  1    packer accepts byte this cycle
//  empty_i        in   1    1-cycle pulse: zero-length message end
//  data_o         out  128  packed block; byte k at bits [8k+7:8k] (bytes 0-7 -> S0)
//  block_valid_o  out  1    data_o/bytes_o/block_last_o valid
//  block_ready_i  in   1    consumer takes block this cycle
//  block_last_o   out  1    block carries the padding (final block of message)
//  bytes_o        out  5    data bytes in block, 0..16 (for ciphertext truncation)
//  proto_err_o    out  1    sticky protocol error flag
// BEHAVIOUR
//  - Reset: data buffer=0, count=0, state FILL, all outputs 0 (byte_ready_o 0 while reset_i=1).
//  - States: FILL (byte_ready_o=1), EMIT (block_valid_o=1), EXTRA (block_valid_o=1, pad-only block).
//  - FILL: byte accepted when byte_valid_i & byte_ready_o; written at position count, count++.
//    * new count=16, not last -> EMIT, bytes_o=16, block_last_o=0.
//    * last, new count<16 -> PAD_BYTE written at position new count, EMIT,
//      bytes_o=new count, block_last_o=1.
//    * last, new count=16 -> EMIT (bytes_o=16, block_last_o=0), then EXTRA.
//    * empty_i with count=0 -> EMIT with data_o=128'h01, bytes_o=0, block_last_o=1.
//  - Latency: accepting the completing byte in cycle N -> block_valid_o=1 in cycle N+1.
//  - EMIT/EXTRA: byte_ready_o=0; data_o, bytes_o, block_last_o held stable until block_ready_i.
//    On block_ready_i: buffer cleared to 0, count=0; EMIT->EXTRA if pending, else ->FILL.
//    EXTRA presents data_o=128'h01, bytes_o=0, block_last_o=1; on block_ready_i ->FILL.
//  - block_ready_i while block_valid_o=0: ignored.
//  - One bubble cycle per block (no overlap of fill and emit); accepted.
//  - Errors (set proto_err_o, cleared only by reset):
//    empty_i with count!=0 -> ignored; empty_i with byte_valid_i in the same cycle ->
//    byte wins, empty_i ignored; empty_i in EMIT/EXTRA -> ignored.
//  - Unwritten byte lanes are always 0 (buffer cleared after each hand-off).
//  - Reset mid-operation: partial block discarded; next byte lands in lane 0.
// STRUCTURE
//  - ascon_pack gains: RATE_BYTES, PAD_BYTE constants;
//    typedef enum logic [1:0] {FILL, EMIT, EXTRA} type_packer_state.
//  - Single module; buffer as 16x8 register array with lane-write decode, count 5-bit.
//  - No sub-module.
// TESTING
//  1. 3 bytes AA,BB,CC (last on CC) -> data_o=128'h01CCBBAA, bytes_o=3, block_last_o=1.
//  2. 16 bytes 00..0F, last on 0F -> blk1 data_o=128'h0F0E..0100, bytes_o=16,
//     block_last_o=0; blk2 data_o=128'h01, bytes_o=0, block_last_o=1.
//  3. empty_i pulse in FILL, count=0 -> data_o=128'h01, bytes_o=0, block_last_o=1, proto_err_o=0.
//  4. Block pending, block_ready_i low 5 cycles, byte_valid_i=1 -> data_o stable,
//     byte_ready_o=0, no byte lost; 17 bytes (last on 17th) -> two blocks, 2nd 128'h01<<8|b16.
//  5. reset_i asserted after 7 bytes -> outputs 0 immediately; next 1-byte msg 0x55 (last)
//     -> data_o=128'h0155.
//  6. empty_i with count=2 -> proto_err_o=1, count stays 2, no block emitted.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared constants and state encoding for the ASCON-AEAD128 rate-block packer.
package ascon_pack;

    localparam int         RATE_BYTES = 16;
    localparam logic [7:0] PAD_BYTE   = 8'h01;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT  = 2'd1,
        EXTRA = 2'd2
    } type_packer_state;

endpackage

// File: rtl/ascon_block_packer.sv
// Packs a byte stream into 128-bit ASCON rate blocks and appends the 0x01 padding
// byte, handing each block to the control FSM with a valid/ready handshake.
module ascon_block_packer
    import ascon_pack::type_packer_state;
    import ascon_pack::FILL;
    import ascon_pack::EMIT;
    import ascon_pack::EXTRA;
#(
    parameter int         RATE_BYTES = 16,
    parameter logic [7:0] PAD_BYTE   = 8'h01
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    input  logic                    byte_last_i,
    output logic                    byte_ready_o,
    input  logic                    empty_i,
    output logic [8*RATE_BYTES-1:0] data_o,
    output logic                    block_valid_o,
    input  logic                    block_ready_i,
    output logic                    block_last_o,
    output logic [4:0]              bytes_o,
    output logic                    proto_err_o
);

    localparam int         IDX_W = $clog2(RATE_BYTES);
    localparam logic [4:0] FULL  = 5'(RATE_BYTES);

    type_packer_state state, state_nxt;

    logic [7:0] buffer [RATE_BYTES];
    logic [4:0] count;
    logic [4:0] count_inc;
    logic [4:0] bytes_q;
    logic       last_q;
    logic       extra_pend;
    logic       byte_acc;
    logic       empty_ok;
    logic       empty_bad;

    // Byte acceptance is masked during reset so upstream never sees a handshake then.
    assign byte_ready_o  = (state == FILL) && !reset_i;
    assign block_valid_o = (state != FILL);
    assign bytes_o       = bytes_q;
    assign block_last_o  = last_q;

    assign byte_acc  = byte_valid_i && byte_ready_o;
    assign count_inc = count + 5'd1;
    // A zero-length end marker is only meaningful between messages with no byte competing.
    assign empty_ok  = empty_i && (state == FILL) && !byte_valid_i && (count == 5'd0);
    assign empty_bad = empty_i && !empty_ok;

    always_comb begin
        data_o = '0;
        for (int k = 0; k < RATE_BYTES; k++) begin
            data_o[8*k +: 8] = buffer[k];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (byte_acc && (byte_last_i || (count_inc == FULL))) begin
                    state_nxt = EMIT;
                end else if (empty_ok) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (block_ready_i) begin
                    state_nxt = extra_pend ? EXTRA : FILL;
                end
            end
            EXTRA: begin
                if (block_ready_i) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < RATE_BYTES; i++) begin
                buffer[i] <= '0;
            end
            count       <= '0;
            bytes_q     <= '0;
            last_q      <= 1'b0;
            extra_pend  <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            if (empty_bad) begin
                proto_err_o <= 1'b1;
            end
            case (state)
                FILL: begin
                    if (byte_acc) begin
                        buffer[count[IDX_W-1:0]] <= byte_i;
                        count                    <= count_inc;
                        if (count_inc == FULL) begin
                            // A last byte that fills the block defers its padding to a pad-only block.
                            bytes_q    <= FULL;
                            last_q     <= 1'b0;
                            extra_pend <= byte_last_i;
                        end else if (byte_last_i) begin
                            buffer[count_inc[IDX_W-1:0]] <= PAD_BYTE;
                            bytes_q                      <= count_inc;
                            last_q                       <= 1'b1;
                        end
                    end else if (empty_ok) begin
                        buffer[0] <= PAD_BYTE;
                        bytes_q   <= 5'd0;
                        last_q    <= 1'b1;
                    end
                end
                EMIT: begin
                    if (block_ready_i) begin
                        for (int i = 0; i < RATE_BYTES; i++) begin
                            buffer[i] <= '0;
                        end
                        count   <= '0;
                        bytes_q <= 5'd0;
                        if (extra_pend) begin
                            buffer[0]  <= PAD_BYTE;
                            last_q     <= 1'b1;
                            extra_pend <= 1'b0;
                        end else begin
                            last_q <= 1'b0;
                        end
                    end
                end
                EXTRA: begin
                    if (block_ready_i) begin
                        for (int i = 0; i < RATE_BYTES; i++) begin
                            buffer[i] <= '0;
                        end
                        count   <= '0;
                        bytes_q <= 5'd0;
                        last_q  <= 1'b0;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_block_packer.sv
// Directed bench for the ASCON rate-block packer: padding, full blocks, empty messages,
// back-pressure, mid-message reset and protocol-error detection.
module tb_ascon_block_packer;

    logic         clock_i;
    logic         reset_i;
    logic [7:0]   byte_i;
    logic         byte_valid_i;
    logic         byte_last_i;
    logic         byte_ready_o;
    logic         empty_i;
    logic [127:0] data_o;
    logic         block_valid_o;
    logic         block_ready_i;
    logic         block_last_o;
    logic [4:0]   bytes_o;
    logic         proto_err_o;

    int checks;
    int errors;

    ascon_block_packer dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_last_i   (byte_last_i),
        .byte_ready_o  (byte_ready_o),
        .empty_i       (empty_i),
        .data_o        (data_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .block_last_o  (block_last_o),
        .bytes_o       (bytes_o),
        .proto_err_o   (proto_err_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // Presents one byte, waits (bounded) for acceptance, then drops valid.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        byte_i       = b;
        byte_last_i  = last;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_timeout byte=%h ready=%b required=1", b, byte_ready_o);
        end
        step();
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
    endtask

    task automatic take_block();
        block_ready_i = 1'b1;
        step();
        block_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        checks++;
        if (data_o !== 128'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_o); end
        checks++;
        if (block_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", block_valid_o); end
        checks++;
        if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", byte_ready_o); end
        checks++;
        if ({block_last_o, bytes_o, proto_err_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_misc last=%b bytes=%0d err=%b exp=0", block_last_o, bytes_o, proto_err_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (byte_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", byte_ready_o); end
    endtask

    task automatic test_short_msg();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        checks++;
        if (block_valid_o !== 1'b1) begin errors++; $display("FAIL short_valid got=%b exp=1", block_valid_o); end
        checks++;
        if (data_o !== 128'h01CCBBAA) begin errors++; $display("FAIL short_data got=%h exp=%h", data_o, 128'h01CCBBAA); end
        checks++;
        if (bytes_o !== 5'd3 || block_last_o !== 1'b1) begin
            errors++;
            $display("FAIL short_meta bytes=%0d last=%b exp bytes=3 last=1", bytes_o, block_last_o);
        end
        take_block();
        checks++;
        if (block_valid_o !== 1'b0 || data_o !== 128'h0) begin
            errors++;
            $display("FAIL short_handoff valid=%b data=%h exp valid=0 data=0", block_valid_o, data_o);
        end
    endtask

    task automatic test_full_block();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), i == 15);
        end
        checks++;
        if (data_o !== 128'h0F0E0D0C0B0A09080706050403020100 || block_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL full_data got=%h valid=%b exp=0f0e..0100 valid=1", data_o, block_valid_o);
        end
        checks++;
        if (bytes_o !== 5'd16 || block_last_o !== 1'b0) begin
            errors++;
            $display("FAIL full_meta bytes=%0d last=%b exp bytes=16 last=0", bytes_o, block_last_o);
        end
        take_block();
        checks++;
        if (block_valid_o !== 1'b1 || data_o !== 128'h01 || bytes_o !== 5'd0 || block_last_o !== 1'b1) begin
            errors++;
            $display("FAIL extra_block valid=%b data=%h bytes=%0d last=%b exp 1/01/0/1",
                     block_valid_o, data_o, bytes_o, block_last_o);
        end
        take_block();
        checks++;
        if (block_valid_o !== 1'b0 || byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL extra_handoff valid=%b ready=%b exp valid=0 ready=1", block_valid_o, byte_ready_o);
        end
    endtask

    task automatic test_empty_msg();
        empty_i = 1'b1;
        step();
        empty_i = 1'b0;
        checks++;
        if (block_valid_o !== 1'b1 || data_o !== 128'h01 || bytes_o !== 5'd0 || block_last_o !== 1'b1) begin
            errors++;
            $display("FAIL empty_block valid=%b data=%h bytes=%0d last=%b exp 1/01/0/1",
                     block_valid_o, data_o, bytes_o, block_last_o);
        end
        checks++;
        if (proto_err_o !== 1'b0) begin errors++; $display("FAIL empty_err got=%b exp=0", proto_err_o); end
        take_block();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i), 1'b0);
        end
        byte_i       = 8'h20;
        byte_last_i  = 1'b1;
        byte_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (byte_ready_o !== 1'b0 || data_o !== 128'h1F1E1D1C1B1A19181716151413121110) begin
                errors++;
                $display("FAIL stall_c%0d ready=%b data=%h exp ready=0 data=1f1e..1110", c, byte_ready_o, data_o);
            end
        end
        take_block();
        checks++;
        if (byte_ready_o !== 1'b1 || block_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_release ready=%b valid=%b exp ready=1 valid=0", byte_ready_o, block_valid_o);
        end
        step();
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        checks++;
        if (block_valid_o !== 1'b1 || data_o !== 128'h0120 || bytes_o !== 5'd1 || block_last_o !== 1'b1) begin
            errors++;
            $display("FAIL b16_block valid=%b data=%h bytes=%0d last=%b exp 1/0120/1/1",
                     block_valid_o, data_o, bytes_o, block_last_o);
        end
        take_block();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            send_byte(8'(8'hA0 + i), 1'b0);
        end
        reset_i = 1'b1;
        #1;
        checks++;
        if (data_o !== 128'h0 || byte_ready_o !== 1'b0 || block_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset data=%h ready=%b valid=%b exp all 0", data_o, byte_ready_o, block_valid_o);
        end
        step();
        reset_i = 1'b0;
        #1;
        send_byte(8'h55, 1'b1);
        checks++;
        if (data_o !== 128'h0155 || bytes_o !== 5'd1 || block_last_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_next data=%h bytes=%0d last=%b exp 0155/1/1", data_o, bytes_o, block_last_o);
        end
        take_block();
    endtask

    task automatic test_idle_ready();
        send_byte(8'h42, 1'b0);
        block_ready_i = 1'b1;
        step();
        block_ready_i = 1'b0;
        send_byte(8'h43, 1'b1);
        checks++;
        if (data_o !== 128'h014342 || bytes_o !== 5'd2) begin
            errors++;
            $display("FAIL idle_ready data=%h bytes=%0d exp 014342/2", data_o, bytes_o);
        end
        take_block();
    endtask

    task automatic test_proto_err();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        empty_i = 1'b1;
        step();
        empty_i = 1'b0;
        checks++;
        if (proto_err_o !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", proto_err_o); end
        checks++;
        if (block_valid_o !== 1'b0) begin errors++; $display("FAIL err_no_block got=%b exp=0", block_valid_o); end
        send_byte(8'h33, 1'b1);
        checks++;
        if (data_o !== 128'h01332211 || bytes_o !== 5'd3 || proto_err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_count data=%h bytes=%0d err=%b exp 01332211/3/1", data_o, bytes_o, proto_err_o);
        end
        take_block();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_i       = 1'b1;
        byte_i        = 8'h00;
        byte_valid_i  = 1'b0;
        byte_last_i   = 1'b0;
        empty_i       = 1'b0;
        block_ready_i = 1'b0;
        step();
        test_reset();
        test_short_msg();
        test_full_block();
        test_empty_msg();
        test_back_to_back();
        test_reset_mid();
        test_idle_ready();
        test_proto_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
